conf_int_div__iter__arch_agnos: RTL and testbench
=================================================

Name: conf_int_div__iter__arch_agnos

Overview:
Configurable-precision unsigned integer divider; the inverse of the datapath multiplier. It accepts a 2*DATA_PATH_BITWIDTH dividend, which is the width of a multiplier product, and a DATA_PATH_BITWIDTH divisor. It returns quotient and remainder through a radix-2 restoring iteration, one quotient bit per cycle. OP_BITWIDTH sets the effective precision, and therefore both latency and accuracy, for precision/energy sweeps.

Parameters:
OP_BITWIDTH, 16, effective operand width; divisor uses low OP_BITWIDTH bits, dividend uses low 2*OP_BITWIDTH bits; must be 1..DATA_PATH_BITWIDTH.
DATA_PATH_BITWIDTH, 16, physical port width; upper bits above OP width are ignored on inputs and driven 0 on outputs.

Ports:
clk  input  1  clock; all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; accepted only when ready=1
a  input  2*DATA_PATH_BITWIDTH  dividend, sampled on accepted start
b  input  DATA_PATH_BITWIDTH  divisor, sampled on accepted start
ready  output  1  high in IDLE and DONE; block can accept start
done  output  1  single-cycle pulse when results become valid
q  output  2*DATA_PATH_BITWIDTH  quotient, held until next accepted start
r  output  DATA_PATH_BITWIDTH  remainder, held until next accepted start
dbz  output  1  divide-by-zero flag for the held result

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, ready=1, done=0, q=0, r=0, dbz=0, counter=0. Reset wins over start in the same cycle.
- Reset mid-operation aborts the division and discards partial results.
- FSM has three states: IDLE, RUN, DONE.
  - IDLE/DONE with start=1: latch masked a/b, clear partial remainder, set count=2*OP_BITWIDTH, clear q/r/dbz, go RUN, ready=0.
  - DONE with start=0: stay DONE, holding q/r/dbz.
  - Start in DONE is a legal back-to-back accept.
- RUN step, each cycle:
  - rem = {rem, next dividend MSB}, with rem OP_BITWIDTH+1 bits wide.
  - If rem >= divisor, then rem -= divisor and shift 1 into the quotient; else shift 0.
  - Decrement count. At count==1, go DONE next cycle.
- DONE entry: q/r/dbz registered, done=1 for exactly that cycle, ready=1.
- Latency: start sampled at edge T; done=1 in the cycle following edge T+2*OP_BITWIDTH, i.e. 2*OP_BITWIDTH cycles in RUN. This latency is fixed unless the optional feature is enabled.
- start while RUN is ignored, with no effect on state or operands.
- Divisor==0 result: q = all ones in low 2*OP_BITWIDTH bits, r = low OP_BITWIDTH bits of masked dividend, dbz=1. This is forced at DONE regardless of the iteration result.
- Output widths: q upper 2*(DATA_PATH_BITWIDTH-OP_BITWIDTH) bits = 0; r upper DATA_PATH_BITWIDTH-OP_BITWIDTH bits = 0.
- Quotient can need the full 2*OP_BITWIDTH bits, e.g. b=1; there is no overflow condition.

Optional Feature:
CONF_INT_DIV_EARLY_OUT_EN.
- Defined: on accept, if masked divisor==0, or masked dividend < masked divisor, go directly IDLE->DONE. done pulses in the cycle after the start edge, with q=0 and r=dividend (or the dbz result for divisor==0).
- Undefined: every operation takes the full 2*OP_BITWIDTH RUN cycles. Results are identical either way; only latency differs.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE/RUN/DONE, 2-bit);
  - counter width constant: clog2(2*OP_BITWIDTH+1);
  - divide-by-zero quotient/remainder constant functions, shared with the multiplier verification model.
- Natural sub-module: conf_int_div__step, a combinational one-bit restore/subtract cell (rem_in, dividend bit, divisor -> rem_out, q_bit). The top holds the FSM, counter and registers.

Test Plan:
- OP=DW=16, a=100, b=7, start one cycle -> done exactly 32 cycles after accept; q=14, r=2, dbz=0.
- a=0xFFFF_FFFF, b=0xFFFF -> q=0x0001_0001, r=0.
- a=0x1234, b=0 -> q=0xFFFF_FFFF, r=0x1234, dbz=1; with CONF_INT_DIV_EARLY_OUT_EN, done 1 cycle after accept.
- OP=8, DW=16: a=0x1234_0564, b=0x0A0C (masked 1380/12) -> q=115, r=0; done 16 cycles after accept; upper output bits 0.
- start pulsed again mid-RUN with a=9, b=3 -> ignored, first result unchanged. Back-to-back start in the DONE cycle -> accepted, second result correct.
- rst asserted at RUN cycle 10 -> next cycle IDLE, ready=1, q=r=0, no done pulse. A following fresh start completes normally.

Source files
------------

// File: rtl/conf_int_div__iter__arch_agnos_pkg.sv
// Shared definitions for the iterative restoring divider: FSM state type,
// counter sizing and the divide-by-zero result constants. The divide-by-zero
// helpers are also used by the multiplier verification model.
package conf_int_div__iter__arch_agnos_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // Widest datapath the helper functions can describe (2*DATA_PATH_BITWIDTH).
  localparam int MAX_W = 64;

  // Counter must hold the value 2*op_bits.
  function automatic int cnt_width(input int op_bits);
    return $clog2(2 * op_bits + 1);
  endfunction

  // Divide-by-zero quotient: all ones in the low 2*op_bits bits.
  function automatic logic [MAX_W-1:0] dbz_quotient(input int op_bits);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) v[i] = (i < 2 * op_bits);
    return v;
  endfunction

  // Divide-by-zero remainder: low op_bits bits of the dividend.
  function automatic logic [MAX_W-1:0] dbz_remainder(input logic [MAX_W-1:0] dividend,
                                                     input int op_bits);
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < MAX_W; i++) v[i] = (i < op_bits) ? dividend[i] : 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/conf_int_div__iter__arch_agnos_if.sv
// Request/result bundle of the iterative divider. The master side issues
// start with operands; the slave side returns ready/done and the held result.
interface conf_int_div__iter__arch_agnos_if #(
  parameter int DATA_PATH_BITWIDTH = 16
);
  logic                              start;
  logic [2*DATA_PATH_BITWIDTH-1:0]   a;
  logic [DATA_PATH_BITWIDTH-1:0]     b;
  logic                              ready;
  logic                              done;
  logic [2*DATA_PATH_BITWIDTH-1:0]   q;
  logic [DATA_PATH_BITWIDTH-1:0]     r;
  logic                              dbz;

  modport master (output start, a, b, input ready, done, q, r, dbz);
  modport slave  (input start, a, b, output ready, done, q, r, dbz);
endinterface

// File: rtl/conf_int_div__step.sv
// One radix-2 restoring step: append the next dividend bit to the partial
// remainder, subtract the divisor when it fits and emit the quotient bit.
// The partial remainder stays below the divisor between steps, so W bits
// hold it; the appended value needs W+1 bits and the trial difference W+2
// so that its top bit is an exact borrow.
module conf_int_div__step #(
  parameter int W = 16
) (
  input  logic [W-1:0] rem_in,
  input  logic         dividend_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic         q_bit
);
  logic [W:0]   trial;
  logic [W+1:0] diff;
  logic         unused_diff;

  // Trial subtraction; restore (keep the shifted value) when it borrows.
  always_comb begin
    trial   = {rem_in, dividend_bit};
    diff    = {1'b0, trial} - {2'b00, divisor};
    q_bit   = ~diff[W+1];
    rem_out = q_bit ? diff[W-1:0] : trial[W-1:0];
  end

  assign unused_diff = diff[W];
endmodule

// File: rtl/conf_int_div__iter__arch_agnos.sv
// Iterative unsigned divider, one quotient bit per cycle. Divides a
// 2*OP_BITWIDTH dividend by an OP_BITWIDTH divisor taken from the low bits
// of the physical ports; the unused upper output bits are driven 0.
// Optional macro CONF_INT_DIV_EARLY_OUT_EN: finish immediately when the
// divisor is zero or the dividend is smaller than the divisor.
module conf_int_div__iter__arch_agnos
  import conf_int_div__iter__arch_agnos_pkg::*;
#(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  conf_int_div__iter__arch_agnos_if.slave bus
);
  localparam int N     = OP_BITWIDTH;
  localparam int QW    = 2 * OP_BITWIDTH;
  localparam int CNT_W = cnt_width(OP_BITWIDTH);
  localparam logic [MAX_W-1:0] DBZ_Q_ALL = dbz_quotient(OP_BITWIDTH);
  localparam logic [QW-1:0]    DBZ_Q     = DBZ_Q_ALL[QW-1:0];

  div_state_t        state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [QW-1:0]     dvd;
  logic [N-1:0]      dvs;
  logic [N-1:0]      rem;
  logic [QW-1:0]     quo;
  logic [N-1:0]      dbz_rem;
  logic [QW-1:0]     q_reg;
  logic [N-1:0]      r_reg;
  logic              dbz_reg;
  logic              done_r;

  logic [QW-1:0]     a_m;
  logic [N-1:0]      b_m;
  logic [MAX_W-1:0]  dbz_r_all;
  logic [N-1:0]      dbz_r_in;
  logic              accept;
  logic              early;
  logic [N-1:0]      rem_n;
  logic              q_bit;
  logic              unused_bits;

  assign a_m       = bus.a[QW-1:0];
  assign b_m       = bus.b[N-1:0];
  assign dbz_r_all = dbz_remainder(MAX_W'(a_m), N);
  assign dbz_r_in  = dbz_r_all[N-1:0];
  assign accept    = bus.start && (state == S_IDLE || state == S_DONE);

`ifdef CONF_INT_DIV_EARLY_OUT_EN
  assign early = (b_m == '0) || (a_m < QW'(b_m));
`else
  assign early = 1'b0;
`endif

  conf_int_div__step #(.W(N)) u_step (
    .rem_in       (rem),
    .dividend_bit (dvd[QW-1]),
    .divisor      (dvs),
    .rem_out      (rem_n),
    .q_bit        (q_bit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next state: accept from IDLE/DONE, leave RUN after the last step.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (accept) state_n = early ? S_DONE : S_RUN;
      S_RUN:          if (cnt == CNT_W'(1)) state_n = S_DONE;
      default:        state_n = S_IDLE;
    endcase
  end

  // Operand latch, iteration registers and held result with the done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      quo     <= '0;
      dbz_rem <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dbz_reg <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            dvd     <= a_m;
            dvs     <= b_m;
            rem     <= '0;
            quo     <= '0;
            dbz_rem <= dbz_r_in;
            cnt     <= CNT_W'(QW);
            q_reg   <= '0;
            r_reg   <= '0;
            dbz_reg <= 1'b0;
            if (early) begin
              cnt     <= '0;
              done_r  <= 1'b1;
              dbz_reg <= (b_m == '0);
              q_reg   <= (b_m == '0) ? DBZ_Q : '0;
              r_reg   <= (b_m == '0) ? dbz_r_in : a_m[N-1:0];
            end
          end
        end
        S_RUN: begin
          rem <= rem_n;
          quo <= {quo[QW-2:0], q_bit};
          dvd <= {dvd[QW-2:0], 1'b0};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            done_r <= 1'b1;
            if (dvs == '0) begin
              q_reg   <= DBZ_Q;
              r_reg   <= dbz_rem;
              dbz_reg <= 1'b1;
            end else begin
              q_reg   <= {quo[QW-2:0], q_bit};
              r_reg   <= rem_n;
              dbz_reg <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state == S_IDLE) || (state == S_DONE);
  assign bus.done  = done_r;
  assign bus.q     = (2*DATA_PATH_BITWIDTH)'(q_reg);
  assign bus.r     = DATA_PATH_BITWIDTH'(r_reg);
  assign bus.dbz   = dbz_reg;

  assign unused_bits = ^{bus.a, bus.b, dbz_r_all};
endmodule

// File: tb/tb_conf_int_div__iter__arch_agnos.sv
// Bench for the iterative divider: a 16-bit precision instance and an 8-bit
// precision instance on a 16-bit datapath, checked against plain integer
// division. Follows CONF_INT_DIV_EARLY_OUT_EN for the expected latency.
module tb_conf_int_div__iter__arch_agnos;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  conf_int_div__iter__arch_agnos_if #(.DATA_PATH_BITWIDTH(DW)) bus16 ();
  conf_int_div__iter__arch_agnos_if #(.DATA_PATH_BITWIDTH(DW)) bus8 ();

  conf_int_div__iter__arch_agnos #(.OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(DW)) dut16 (
    .clk (clk), .rst (rst), .bus (bus16.slave));
  conf_int_div__iter__arch_agnos #(.OP_BITWIDTH(8), .DATA_PATH_BITWIDTH(DW)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8.slave));

  // Reference: integer division of the masked operands, edges from accept to done.
  task automatic ref_div(input logic [63:0] a, input logic [63:0] b, input int op,
                         output logic [63:0] q, output logic [63:0] r,
                         output logic dbz, output int lat);
    logic [63:0] qmask, rmask, am, bm;
    qmask = (64'd1 << (2 * op)) - 64'd1;
    rmask = (64'd1 << op) - 64'd1;
    am = a & qmask;
    bm = b & rmask;
    if (bm == 0) begin
      q = qmask; r = am & rmask; dbz = 1'b1;
    end else begin
      q = am / bm; r = am % bm; dbz = 1'b0;
    end
    lat = 2 * op;
`ifdef CONF_INT_DIV_EARLY_OUT_EN
    if (bm == 0 || am < bm) lat = 0;
`endif
  endtask

  task automatic issue_start(input bit sel, input logic [31:0] a, input logic [15:0] b);
    if (sel) begin bus8.start = 1'b1; bus8.a = a; bus8.b = b; end
    else     begin bus16.start = 1'b1; bus16.a = a; bus16.b = b; end
    @(posedge clk);
    #1;
    bus8.start  = 1'b0;
    bus16.start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int edges, output logic [31:0] q,
                           output logic [15:0] r, output logic dbz, output bit timeout);
    bit seen;
    seen = 1'b0; edges = 0; timeout = 1'b0; q = '0; r = '0; dbz = 1'b0;
    while (!seen) begin
      @(negedge clk);
      if (sel ? bus8.done : bus16.done) begin
        seen = 1'b1;
        q   = sel ? bus8.q : bus16.q;
        r   = sel ? bus8.r : bus16.r;
        dbz = sel ? bus8.dbz : bus16.dbz;
      end else if (edges >= 300) begin
        timeout = 1'b1; seen = 1'b1;
      end else begin
        @(posedge clk);
        edges++;
      end
    end
  endtask

  // Issue one operation and return what the selected instance produced.
  task automatic applyStimulus(input bit sel, input logic [31:0] a, input logic [15:0] b,
                               output int edges, output logic [31:0] q,
                               output logic [15:0] r, output logic dbz, output bit timeout);
    issue_start(sel, a, b);
    wait_done(sel, edges, q, r, dbz, timeout);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus16.start = 1'b0; bus16.a = '0; bus16.b = '0;
    bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0;
    repeat (2) @(posedge clk);
    #1;
    bus16.start = 1'b1; bus16.a = 32'd100; bus16.b = 16'd7;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus16.start = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus16.ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", bus16.ready);
    else n_pass++;
    n_checks++;
    if (bus16.done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", bus16.done);
    else n_pass++;
    n_checks++;
    if (bus16.q !== 32'd0) $display("[TB] FAIL reset_q: got %0h expected 0", bus16.q);
    else n_pass++;
    n_checks++;
    if (bus16.r !== 16'd0 || bus16.dbz !== 1'b0)
      $display("[TB] FAIL reset_r_dbz: got r=%0h dbz=%b expected r=0 dbz=0", bus16.r, bus16.dbz);
    else n_pass++;
    n_checks++;
    if (bus8.ready !== 1'b1 || bus8.q !== 32'd0)
      $display("[TB] FAIL reset_op8: got ready=%b q=%0h expected ready=1 q=0", bus8.ready, bus8.q);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [31:0] ta [3] = '{32'd100, 32'hFFFF_FFFF, 32'h0000_1234};
    logic [15:0] tb [3] = '{16'd7, 16'hFFFF, 16'h0000};
    logic [31:0] eq [3] = '{32'd14, 32'h0001_0001, 32'hFFFF_FFFF};
    logic [15:0] er [3] = '{16'd2, 16'h0000, 16'h1234};
    logic        ed [3] = '{1'b0, 1'b0, 1'b1};
    int          el;
    int edges; logic [31:0] q; logic [15:0] r; logic dbz; bit to;
    for (int i = 0; i < 3; i++) begin
      el = 32;
`ifdef CONF_INT_DIV_EARLY_OUT_EN
      if (i == 2) el = 0;
`endif
      applyStimulus(1'b0, ta[i], tb[i], edges, q, r, dbz, to);
      n_checks++;
      if (to) $display("[TB] FAIL directed%0d_timeout: no done within 300 cycles", i);
      else n_pass++;
      n_checks++;
      if ({q, r, dbz} !== {eq[i], er[i], ed[i]})
        $display("[TB] FAIL directed%0d_result: got q=%0h r=%0h dbz=%b expected q=%0h r=%0h dbz=%b",
                 i, q, r, dbz, eq[i], er[i], ed[i]);
      else n_pass++;
      n_checks++;
      if (edges !== el) $display("[TB] FAIL directed%0d_latency: got %0d expected %0d", i, edges, el);
      else n_pass++;
      if (i == 0) begin
        @(negedge clk);
        n_checks++;
        if ({bus16.done, bus16.ready, bus16.q} !== {1'b0, 1'b1, 32'd14})
          $display("[TB] FAIL done_pulse_hold: got done=%b ready=%b q=%0h expected done=0 ready=1 q=e",
                   bus16.done, bus16.ready, bus16.q);
        else n_pass++;
      end
    end
  endtask

  task automatic test_op8();
    int edges; logic [31:0] q; logic [15:0] r; logic dbz; bit to;
    applyStimulus(1'b1, 32'h1234_0564, 16'h0A0C, edges, q, r, dbz, to);
    n_checks++;
    if (to || {q, r, dbz} !== {32'd115, 16'd0, 1'b0})
      $display("[TB] FAIL op8_result: got q=%0h r=%0h dbz=%b timeout=%b expected q=73 r=0 dbz=0",
               q, r, dbz, to);
    else n_pass++;
    n_checks++;
    if (edges !== 16) $display("[TB] FAIL op8_latency: got %0d expected 16", edges);
    else n_pass++;
  endtask

  task automatic test_random();
    int edges, el, mode, op; logic [31:0] q, a; logic [15:0] r, b; logic dbz, edbz; bit to;
    logic [63:0] eq, er;
    for (int s = 0; s < 2; s++) begin
      op = (s == 1) ? 8 : 16;
      for (int i = 0; i < 30; i++) begin
        mode = $urandom_range(0, 3);
        a = $urandom;
        b = 16'($urandom);
        if (mode == 0) b = (op == 8) ? (b & 16'hFF00) : 16'h0000;
        else if (mode == 1) b = (b & 16'hFF00) | 16'(($urandom_range(1, 3)));
        else if (mode == 3) a = 32'($urandom_range(0, 300));
        ref_div({32'd0, a}, {48'd0, b}, op, eq, er, edbz, el);
        applyStimulus(s[0], a, b, edges, q, r, dbz, to);
        n_checks++;
        if (to || {q, r, dbz} !== {eq[31:0], er[15:0], edbz} || edges !== el)
          $display("[TB] FAIL random_op%0d: a=%0h b=%0h got q=%0h r=%0h dbz=%b lat=%0d to=%b expected q=%0h r=%0h dbz=%b lat=%0d",
                   op, a, b, q, r, dbz, edges, to, eq[31:0], er[15:0], edbz, el);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int edges; logic [31:0] q; logic [15:0] r; logic dbz; bit to;
    issue_start(1'b0, 32'd100, 16'd7);
    repeat (5) @(posedge clk);
    #1;
    bus16.start = 1'b1; bus16.a = 32'd9; bus16.b = 16'd3;
    @(posedge clk);
    #1;
    bus16.start = 1'b0;
    wait_done(1'b0, edges, q, r, dbz, to);
    n_checks++;
    if (to || {q, r, dbz} !== {32'd14, 16'd2, 1'b0} || edges + 6 !== 32)
      $display("[TB] FAIL ignore_mid_start: got q=%0h r=%0h dbz=%b lat=%0d expected q=e r=2 dbz=0 lat=32",
               q, r, dbz, edges + 6);
    else n_pass++;
    applyStimulus(1'b0, 32'd1000, 16'd33, edges, q, r, dbz, to);
    n_checks++;
    if (to || {q, r, dbz} !== {32'd30, 16'd10, 1'b0} || edges !== 32)
      $display("[TB] FAIL back_to_back: got q=%0h r=%0h dbz=%b lat=%0d expected q=1e r=a dbz=0 lat=32",
               q, r, dbz, edges);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int edges, seen_done; logic [31:0] q; logic [15:0] r; logic dbz; bit to;
    issue_start(1'b0, 32'd100, 16'd7);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({bus16.ready, bus16.done, bus16.q, bus16.r, bus16.dbz} !== {1'b1, 1'b0, 32'd0, 16'd0, 1'b0})
      $display("[TB] FAIL reset_mid_state: got ready=%b done=%b q=%0h r=%0h dbz=%b expected 1 0 0 0 0",
               bus16.ready, bus16.done, bus16.q, bus16.r, bus16.dbz);
    else n_pass++;
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus16.done) seen_done++;
    end
    n_checks++;
    if (seen_done !== 0) $display("[TB] FAIL reset_mid_no_done: got %0d done pulses expected 0", seen_done);
    else n_pass++;
    applyStimulus(1'b0, 32'd200, 16'd9, edges, q, r, dbz, to);
    n_checks++;
    if (to || {q, r, dbz} !== {32'd22, 16'd2, 1'b0} || edges !== 32)
      $display("[TB] FAIL reset_mid_fresh: got q=%0h r=%0h dbz=%b lat=%0d expected q=16 r=2 dbz=0 lat=32",
               q, r, dbz, edges);
    else n_pass++;
  endtask

  initial begin
    $display("[TB] starting divider bench");
    test_reset();
    test_directed();
    test_op8();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
